// File: rtl/multicycle_control_fsm.sv
// Purpose: multicycle RV32I control unit, a Moore FSM sequencing fetch/decode/execute/writeback.
// Latency: control outputs follow the current state, and FETCH also follows mem_ready_i. An instruction takes 3-5 cycles plus memory waits.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready_i is sampled high.
//
// Ports:
//   clk, rst       : single rising-edge clock; asynchronous active-high reset
//   opcode_i[6:0]  : opcode field of the registered instruction (captured in DECODE)
//   mem_ready_i    : memory has completed the current request
//   mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_update_o, branch_o, reg_write_o
//   result_src_o[1:0], alu_src_a_o[1:0], alu_src_b_o[1:0], alu_op_o[1:0], imm_src_o[2:0]
//   state_o[3:0]   : current state. States are encoded 0..15 in the order FETCH, DECODE,
//                    MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH,
//                    JAL, JALR, LINK, LUI, AUIPC, TRAP.
//   retired_o      : retired-instruction count (wraps)
//   wait_cnt_o     : wait cycles spent in the current/last memory access (saturates)
//   illegal_o      : sticky illegal-opcode flag (trap build only)
//
// Build option: define ILLEGAL_TRAP_EN to send illegal opcodes to a TRAP state that
// holds until reset. When it is undefined, illegal opcodes retire as a NOP.
module multicycle_control_fsm #(
  parameter int CNT_W  = 32,
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode_i,
  input  logic              mem_ready_i,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic              adr_src_o,
  output logic              ir_write_o,
  output logic              pc_update_o,
  output logic              branch_o,
  output logic              reg_write_o,
  output logic [1:0]        result_src_o,
  output logic [1:0]        alu_src_a_o,
  output logic [1:0]        alu_src_b_o,
  output logic [1:0]        alu_op_o,
  output logic [2:0]        imm_src_o,
  output logic [3:0]        state_o,
  output logic [CNT_W-1:0]  retired_o,
  output logic [WAIT_W-1:0] wait_cnt_o,
  output logic              illegal_o
);

  // State encoding
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LINK     = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_AUIPC    = 4'd14;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP     = 4'd15;
`endif

  // Opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]        state_q,    state_d;
  logic [6:0]        opcode_q,   opcode_d;
  logic [CNT_W-1:0]  retired_q,  retired_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // States that issue a memory request and stall on mem_ready_i.
  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Later states (MEMADR) steer on this captured copy, not the live input.
        opcode_d = opcode_i;
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          // Unknown opcode retires as a NOP.
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        state_d = (opcode_q == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI, S_JAL, S_AUIPC: begin
        state_d = S_ALUWB;
      end
      S_JALR: begin
        state_d = S_LINK;
      end
      S_MEMWB, S_ALUWB, S_BRANCH, S_LINK, S_LUI: begin
        state_d = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        // Only reset leaves TRAP.
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    retired_d  = retired_q;

    if (is_mem_state(state_q) && !mem_ready_i && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WAIT_ONE;
    end
    // Entering a memory state starts a fresh count. A stalled state never changes,
    // so this cannot collide with the increment above.
    if (is_mem_state(state_d) && (state_d != state_q)) begin
      wait_cnt_d = '0;
    end

    // Every return to FETCH comes from a terminal state, so it marks one retirement.
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      retired_d = retired_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      opcode_q   <= '0;
      retired_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      retired_q  <= retired_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Moore output decode (FETCH additionally gates IR/PC writes on mem_ready_i)
  // operand A: 00 PC, 01 OldPC, 10 rd1
  // operand B: 00 rd2, 01 imm, 10 const 4
  // result:    00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
  // alu_op:    00 add, 01 sub, 10 funct-decoded
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_update_o  = 1'b0;
    branch_o     = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_update_o  = mem_ready_i;
      end
      S_DECODE: begin
        // OldPC + imm: branch target precomputed speculatively.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        branch_o    = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update_o = 1'b1;
      end
      S_JALR: begin
        alu_src_a_o  = 2'b10;
        alu_src_b_o  = 2'b01;
        result_src_o = 2'b10;
        pc_update_o  = 1'b1;
      end
      S_LINK: begin
        alu_src_a_o  = 2'b01;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        reg_write_o  = 1'b1;
      end
      S_LUI: begin
        result_src_o = 2'b11;
        reg_write_o  = 1'b1;
      end
      S_AUIPC: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      default: begin
        // TRAP (and unreachable codes): every control output stays low.
      end
    endcase
  end

  // Immediate format follows the live opcode in every state.
  always_comb begin
    imm_src_o = 3'b000;
    case (opcode_i)
      OP_STORE:                    imm_src_o = 3'b001;
      OP_BR:                       imm_src_o = 3'b010;
      OP_JAL:                      imm_src_o = 3'b011;
      OP_LUI, OP_AUIPC:            imm_src_o = 3'b100;
      default:                     imm_src_o = 3'b000;
    endcase
  end

  assign state_o    = state_q;
  assign retired_o  = retired_q;
  assign wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Purpose: directed bench for multicycle_control_fsm with a per-cycle expectation queue.
// Latency: inputs are driven on the falling edge, and outputs are compared 1 time unit later.
// Backpressure: memory waits are injected by holding mem_ready_i low in memory states.
module tb_multicycle_control_fsm;

  localparam int CNT_W  = 4;
  localparam int WAIT_W = 4;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LINK     = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_AUIPC    = 4'd14;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic              clk;
  logic              rst;
  logic [6:0]        opcode_i;
  logic              mem_ready_i;
  logic              mem_req_o, mem_write_o, adr_src_o, ir_write_o;
  logic              pc_update_o, branch_o, reg_write_o;
  logic [1:0]        result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o;
  logic [2:0]        imm_src_o;
  logic [3:0]        state_o;
  logic [CNT_W-1:0]  retired_o;
  logic [WAIT_W-1:0] wait_cnt_o;
  logic              illegal_o;

  multicycle_control_fsm #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode_i     (opcode_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_write_o  (mem_write_o),
    .adr_src_o    (adr_src_o),
    .ir_write_o   (ir_write_o),
    .pc_update_o  (pc_update_o),
    .branch_o     (branch_o),
    .reg_write_o  (reg_write_o),
    .result_src_o (result_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .imm_src_o    (imm_src_o),
    .state_o      (state_o),
    .retired_o    (retired_o),
    .wait_cnt_o   (wait_cnt_o),
    .illegal_o    (illegal_o)
  );

  typedef struct {
    logic [3:0]        st;
    logic [14:0]       ctrl;
    logic [2:0]        imm;
    logic [CNT_W-1:0]  ret;
    logic [WAIT_W-1:0] wcnt;
    logic              ill;
  } exp_t;

  exp_t              sb_q[$];
  int                n_vec = 0;
  int                n_err = 0;
  logic [CNT_W-1:0]  m_ret;
  logic [WAIT_W-1:0] m_wait;
  logic [3:0]        m_prev;
  logic [6:0]        cur_op;
  string             cur_name;

  wire [14:0] ctrl_obs = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_update_o,
                          branch_o, reg_write_o, result_src_o, alu_src_a_o,
                          alu_src_b_o, alu_op_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mem(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  // Expected control word {mem_req, mem_write, adr_src, ir_write, pc_update, branch,
  // reg_write, result_src, alu_src_a, alu_src_b, alu_op} for each state.
  function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    logic mreq, mwr, adr, irw, pcu, br, rw;
    logic [1:0] res, a, b, op;
    {mreq, mwr, adr, irw, pcu, br, rw} = 7'b0;
    {res, a, b, op} = 8'b0;
    case (st)
      S_FETCH:    begin mreq = 1'b1; b = 2'b10; res = 2'b10; irw = rdy; pcu = rdy; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_EXECI:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
      S_MEMREAD:  begin mreq = 1'b1; adr = 1'b1; end
      S_MEMWRITE: begin mreq = 1'b1; adr = 1'b1; mwr = 1'b1; end
      S_MEMWB:    begin res = 2'b01; rw = 1'b1; end
      S_EXECR:    begin a = 2'b10; op = 2'b10; end
      S_ALUWB:    begin rw = 1'b1; end
      S_BRANCH:   begin a = 2'b10; op = 2'b01; br = 1'b1; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pcu = 1'b1; end
      S_JALR:     begin a = 2'b10; b = 2'b01; res = 2'b10; pcu = 1'b1; end
      S_LINK:     begin a = 2'b01; b = 2'b10; res = 2'b10; rw = 1'b1; end
      S_LUI:      begin res = 2'b11; rw = 1'b1; end
      S_AUIPC:    begin a = 2'b01; b = 2'b01; end
      default:    begin end
    endcase
    return {mreq, mwr, adr, irw, pcu, br, rw, res, a, b, op};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      OP_STORE:         return 3'b001;
      OP_BR:            return 3'b010;
      OP_JAL:           return 3'b011;
      OP_LUI, OP_AUIPC: return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  // One clock cycle: drive inputs, push the expectation, then pop and compare.
  task automatic cyc(input logic [3:0] st, input logic rdy);
    exp_t e;
    mem_ready_i = rdy;
    opcode_i    = cur_op;
    if (st != m_prev) begin
      if (st == S_FETCH) m_ret = m_ret + 1'b1;
      if (is_mem(st))    m_wait = '0;
    end
    e.st   = st;
    e.ctrl = exp_ctrl(st, rdy);
    e.imm  = exp_imm(cur_op);
    e.ret  = m_ret;
    e.wcnt = m_wait;
    e.ill  = (st == S_TRAP);
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    chk({cur_name, ".state"},   32'(state_o),    32'(e.st));
    chk({cur_name, ".ctrl"},    32'(ctrl_obs),   32'(e.ctrl));
    chk({cur_name, ".imm"},     32'(imm_src_o),  32'(e.imm));
    chk({cur_name, ".retired"}, 32'(retired_o),  32'(e.ret));
    chk({cur_name, ".wait"},    32'(wait_cnt_o), 32'(e.wcnt));
    chk({cur_name, ".illegal"}, 32'(illegal_o),  32'(e.ill));
    if (is_mem(st) && !rdy && (m_wait != '1)) m_wait = m_wait + 1'b1;
    m_prev = st;
    @(negedge clk);
  endtask

  task automatic mem(input logic [3:0] st, input int waits);
    repeat (waits) cyc(st, 1'b0);
    cyc(st, 1'b1);
  endtask

  task automatic instr(input string name, input logic [6:0] op, input int fw, input int mw);
    cur_name = name;
    cur_op   = op;
    mem(S_FETCH, fw);
    cyc(S_DECODE, 1'b1);
    case (op)
      OP_LOAD:  begin cyc(S_MEMADR, 1'b1); mem(S_MEMREAD, mw); cyc(S_MEMWB, 1'b1); end
      OP_STORE: begin cyc(S_MEMADR, 1'b1); mem(S_MEMWRITE, mw); end
      OP_R:     begin cyc(S_EXECR, 1'b1);  cyc(S_ALUWB, 1'b1); end
      OP_I:     begin cyc(S_EXECI, 1'b1);  cyc(S_ALUWB, 1'b1); end
      OP_BR:    cyc(S_BRANCH, 1'b1);
      OP_JAL:   begin cyc(S_JAL, 1'b1);    cyc(S_ALUWB, 1'b1); end
      OP_JALR:  begin cyc(S_JALR, 1'b1);   cyc(S_LINK, 1'b1); end
      OP_LUI:   cyc(S_LUI, 1'b1);
      OP_AUIPC: begin cyc(S_AUIPC, 1'b1);  cyc(S_ALUWB, 1'b1); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        repeat (3) cyc(S_TRAP, 1'b1);
`endif
      end
    endcase
  endtask

  // Called on a falling edge. Reset is raised between clock edges and checked before the next edge.
  task automatic do_reset(input string name);
    #1 rst = 1'b1;
    #1;
    chk({name, ".state"},     32'(state_o),     32'(S_FETCH));
    chk({name, ".mem_write"}, 32'(mem_write_o), 32'd0);
    chk({name, ".retired"},   32'(retired_o),   32'd0);
    chk({name, ".wait"},      32'(wait_cnt_o),  32'd0);
    chk({name, ".illegal"},   32'(illegal_o),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_ret  = '0;
    m_wait = '0;
    m_prev = S_FETCH;
    sb_q.delete();
  endtask

  initial begin
    rst         = 1'b0;
    opcode_i    = '0;
    mem_ready_i = 1'b0;
    cur_op      = '0;
    cur_name    = "init";
    m_ret       = '0;
    m_wait      = '0;
    m_prev      = S_FETCH;
    @(negedge clk);
    do_reset("reset");

    instr("rtype", OP_R, 0, 0);
    #1 chk("rtype.retired_after", 32'(retired_o), 32'd1);
    instr("itype_fw", OP_I, 2, 0);
    instr("load_w3", OP_LOAD, 0, 3);
    instr("store", OP_STORE, 0, 0);
    instr("store_w1", OP_STORE, 0, 1);
    instr("branch", OP_BR, 0, 0);
    instr("jal_fw", OP_JAL, 1, 0);
    instr("jalr", OP_JALR, 0, 0);
    instr("lui", OP_LUI, 0, 0);
    instr("auipc", OP_AUIPC, 0, 0);
    instr("load_sat", OP_LOAD, 0, 17);
    instr("illegal", OP_BAD, 0, 0);
`ifndef ILLEGAL_TRAP_EN
    cur_name = "nop_retire";
    cyc(S_FETCH, 1'b1);
`endif
    do_reset("reset2");

    // Reset in the middle of a stalled store must abandon it without retiring it.
    cur_name = "arst";
    cur_op   = OP_STORE;
    mem(S_FETCH, 0);
    cyc(S_DECODE, 1'b1);
    cyc(S_MEMADR, 1'b1);
    cyc(S_MEMWRITE, 1'b0);
    mem_ready_i = 1'b0;
    #1 chk("arst.pre_write", 32'(mem_write_o), 32'd1);
    do_reset("arst");
    instr("post_rst", OP_R, 0, 0);

    do_reset("reset3");
    for (int i = 0; i < 16; i++) instr("lui_wrap", OP_LUI, 0, 0);
    cur_name = "wrap";
    cyc(S_FETCH, 1'b1);
    #1 chk("wrap.retired_zero", 32'(retired_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
